pipe_skid_reg: RTL and testbench

Parametrised, elastic successor to the fixed inter-stage pipeline registers. It carries one control field and one data field between two pipeline stages over a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`. It adds a synchronous flush that kills in-flight beats and a saturating stall-cycle counter for performance monitoring. It sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces hand-written per-stage registers.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_skid_reg_sat_counter.sv | 20 ++
 rtl/pipe_skid_reg.sv | 157 +++++++++++++++
 tb/tb_pipe_skid_reg.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// skid-buffer state encoding and the per-stage ctrl/data bundle widths.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   localparam int IF_ID_CTRL_W  = 4;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 8;
   localparam int ID_EX_DATA_W  = 128;
   localparam int EX_MEM_CTRL_W = 6;
   localparam int EX_MEM_DATA_W = 112;
   localparam int MEM_WB_CTRL_W = 3;
   localparam int MEM_WB_DATA_W = 72;

   localparam int STALL_CNT_W   = 16;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones,
// cleared only by reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register with optional two-entry skid buffer,
// synchronous flush and a saturating back-pressure cycle counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | nothing held; out_valid=0, ready for a beat
// ST_ONE   | main entry holds the head beat; still ready for a beat
// ST_FULL  | main holds head, skid holds next beat; in_ready low
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W              = ID_EX_CTRL_W,
   parameter int DATA_W              = ID_EX_DATA_W,
   parameter bit REGISTER_READY      = 1'b1,
   parameter bit CLEAR_DATA_ON_FLUSH = 1'b1,
   parameter int CNT_W               = STALL_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   skid_state_e       state;
   skid_state_e       state_nx;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              acc;
   logic              dlv;
   logic              load_main_in;
   logic              load_main_skid;

   assign out_valid = (state != ST_EMPTY);
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;
   assign acc       = in_valid && in_ready;
   assign dlv       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (acc) begin
               load_main_in = 1'b1;
               state_nx     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (acc && dlv) begin
               load_main_in = 1'b1;
            end else if (acc) begin
               state_nx = REGISTER_READY ? ST_FULL : ST_ONE;
            end else if (dlv) begin
               state_nx = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (dlv) begin
               load_main_skid = 1'b1;
               state_nx       = ST_ONE;
            end
         end
         default: state_nx = ST_EMPTY;
      endcase
      // a beat accepted alongside flush is consumed but never stored
      if (flush) begin
         state_nx = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_ctrl <= '0;
         main_data <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
         if (CLEAR_DATA_ON_FLUSH) begin
            main_data <= '0;
         end
      end else if (load_main_in) begin
         main_ctrl <= in_ctrl;
         main_data <= in_data;
      end else if (load_main_skid) begin
         main_ctrl <= skid_ctrl;
         main_data <= skid_data;
      end
   end

   generate
      if (REGISTER_READY) begin : g_skid
         logic load_skid;
         logic ready_q;

         assign load_skid = (state == ST_ONE) && acc && !dlv;

         always_ff @(posedge clk) begin
            if (rst) begin
               skid_ctrl <= '0;
               skid_data <= '0;
            end else if (flush) begin
               skid_ctrl <= '0;
               if (CLEAR_DATA_ON_FLUSH) begin
                  skid_data <= '0;
               end
            end else if (load_skid) begin
               skid_ctrl <= in_ctrl;
               skid_data <= in_data;
            end
         end

         // resets high so the first cycle after reset is already ready
         always_ff @(posedge clk) begin
            if (rst) begin
               ready_q <= 1'b1;
            end else begin
               ready_q <= (state_nx != ST_FULL);
            end
         end

         assign in_ready = ready_q && !rst;
      end else begin : g_noskid
         assign skid_ctrl = '0;
         assign skid_data = '0;
         assign in_ready  = (!out_valid || out_ready) && !rst;
      end
   endgenerate

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid && !out_ready),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg across its main parameter
// variants (skid/clear, skid/hold-data, combinational ready, 2-bit counter).
module tb_pipe_skid_reg;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic         flush;
   logic [7:0]   in_ctrl;
   logic [127:0] in_data;

   logic         in_ready_a, out_valid_a;
   logic [7:0]   out_ctrl_a;
   logic [127:0] out_data_a;
   logic [15:0]  stall_cnt_a;

   logic         in_ready_b, out_valid_b;
   logic [7:0]   out_ctrl_b;
   logic [127:0] out_data_b;
   logic [15:0]  stall_cnt_b;

   logic         in_ready_c, out_valid_c;
   logic [7:0]   out_ctrl_c;
   logic [127:0] out_data_c;
   logic [15:0]  stall_cnt_c;

   logic         in_ready_d, out_valid_d;
   logic [7:0]   out_ctrl_d;
   logic [127:0] out_data_d;
   logic [1:0]   stall_cnt_d;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(.REGISTER_READY(1'b1), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_ctrl(out_ctrl_a), .out_data(out_data_a),
      .flush(flush), .stall_cnt(stall_cnt_a));

   pipe_skid_reg #(.REGISTER_READY(1'b1), .CLEAR_DATA_ON_FLUSH(1'b0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_ctrl(out_ctrl_b), .out_data(out_data_b),
      .flush(flush), .stall_cnt(stall_cnt_b));

   pipe_skid_reg #(.REGISTER_READY(1'b0), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_c),
      .out_ready(out_ready), .out_ctrl(out_ctrl_c), .out_data(out_data_c),
      .flush(flush), .stall_cnt(stall_cnt_c));

   pipe_skid_reg #(.CNT_W(2)) dut_d (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_d),
      .out_ready(out_ready), .out_ctrl(out_ctrl_d), .out_data(out_data_d),
      .flush(flush), .stall_cnt(stall_cnt_d));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      in_ctrl = '0; in_data = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
      in_ctrl = 8'hAA; in_data = 128'h55;
      tick();
      tick();
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready_a); end
      total++; if (in_ready_c !== 1'b0) begin bad++; $display("FAIL rst_in_ready_comb got=%b exp=0", in_ready_c); end
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_a); end
      total++; if (out_ctrl_a !== 8'h00) begin bad++; $display("FAIL rst_out_ctrl got=%h exp=00", out_ctrl_a); end
      total++; if (out_data_a !== 128'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data_a); end
      total++; if (stall_cnt_a !== 16'h0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt_a); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready_a); end
   endtask

   task automatic test_stream();
      logic [7:0]   ec;
      logic [127:0] ed;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ec = 8'(i);
         ed = 128'(256 + i);
         in_valid = 1'b1; in_ctrl = ec; in_data = ed;
         #1;
         total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready_a); end
         tick();
         total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid_a); end
         total++; if (out_ctrl_a !== ec) begin bad++; $display("FAIL stream_ctrl[%0d] got=%h exp=%h", i, out_ctrl_a, ec); end
         total++; if (out_data_a !== ed) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data_a, ed); end
      end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid_a); end
      total++; if (stall_cnt_a !== 16'd0) begin bad++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt_a); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'h10; in_data = 128'h200;
      tick();
      in_ctrl = 8'h11; in_data = 128'h201;
      #1;
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready_a); end
      tick();
      in_ctrl = 8'h12; in_data = 128'h202;
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready_a); end
      total++; if (out_ctrl_a !== 8'h10) begin bad++; $display("FAIL bp_head_ctrl got=%h exp=10", out_ctrl_a); end
      tick();
      tick();
      total++; if (stall_cnt_a !== 16'd3) begin bad++; $display("FAIL bp_stall got=%0d exp=3", stall_cnt_a); end
      total++; if (out_data_a !== 128'h200) begin bad++; $display("FAIL bp_head_stable got=%h exp=200", out_data_a); end
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL bp_ready_hold got=%b exp=0", in_ready_a); end
      out_ready = 1'b1;
      tick();
      total++; if (out_ctrl_a !== 8'h11) begin bad++; $display("FAIL bp_second_ctrl got=%h exp=11", out_ctrl_a); end
      total++; if (out_data_a !== 128'h201) begin bad++; $display("FAIL bp_second_data got=%h exp=201", out_data_a); end
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready_a); end
      tick();
      total++; if (out_ctrl_a !== 8'h12) begin bad++; $display("FAIL bp_third_ctrl got=%h exp=12", out_ctrl_a); end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid_a); end
      total++; if (stall_cnt_a !== 16'd3) begin bad++; $display("FAIL bp_stall_kept got=%0d exp=3", stall_cnt_a); end
   endtask

   task automatic test_flush_clear();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'h31; in_data = 128'h400;
      tick();
      in_ctrl = 8'h32; in_data = 128'h401;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL flc_valid got=%b exp=0", out_valid_a); end
      total++; if (out_ctrl_a !== 8'h00) begin bad++; $display("FAIL flc_ctrl got=%h exp=00", out_ctrl_a); end
      total++; if (out_data_a !== 128'h0) begin bad++; $display("FAIL flc_data got=%h exp=0", out_data_a); end
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL flc_ready got=%b exp=1", in_ready_a); end
      total++; if (stall_cnt_a !== 16'd2) begin bad++; $display("FAIL flc_stall got=%0d exp=2", stall_cnt_a); end
      out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h33; in_data = 128'h402;
      tick();
      in_valid = 1'b0;
      total++; if (out_ctrl_a !== 8'h33) begin bad++; $display("FAIL flc_after_ctrl got=%h exp=33", out_ctrl_a); end
      total++; if (out_data_a !== 128'h402) begin bad++; $display("FAIL flc_after_data got=%h exp=402", out_data_a); end
      tick();
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL flc_skid_gone got=%b exp=0", out_valid_a); end
   endtask

   task automatic test_flush_hold();
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_ctrl = 8'h21; in_data = 128'h300;
      tick();
      flush = 1'b1; in_ctrl = 8'h5A; in_data = 128'h3FF;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL flh_valid got=%b exp=0", out_valid_b); end
      total++; if (out_ctrl_b !== 8'h00) begin bad++; $display("FAIL flh_ctrl got=%h exp=00", out_ctrl_b); end
      total++; if (out_data_b !== 128'h300) begin bad++; $display("FAIL flh_data got=%h exp=300", out_data_b); end
      total++; if (in_ready_b !== 1'b1) begin bad++; $display("FAIL flh_ready got=%b exp=1", in_ready_b); end
      tick();
      tick();
      total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL flh_killed_beat got=%b exp=0", out_valid_b); end
      in_valid = 1'b1; in_ctrl = 8'h22; in_data = 128'h301;
      tick();
      in_valid = 1'b0;
      total++; if (out_ctrl_b !== 8'h22) begin bad++; $display("FAIL flh_after_ctrl got=%h exp=22", out_ctrl_b); end
      total++; if (out_data_b !== 128'h301) begin bad++; $display("FAIL flh_after_data got=%h exp=301", out_data_b); end
   endtask

   task automatic test_comb_ready();
      logic       ordy [6];
      logic       erdy [6];
      logic [7:0] offer [6];
      logic [7:0] ectl [6];
      ordy  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      erdy  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      offer = '{8'h40, 8'h41, 8'h42, 8'h42, 8'h43, 8'h43};
      ectl  = '{8'h40, 8'h41, 8'h41, 8'h42, 8'h42, 8'h43};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         out_ready = ordy[k]; in_valid = 1'b1;
         in_ctrl = offer[k]; in_data = 128'(offer[k]) + 128'h500;
         #1;
         total++; if (in_ready_c !== erdy[k]) begin bad++; $display("FAIL comb_ready[%0d] got=%b exp=%b", k, in_ready_c, erdy[k]); end
         tick();
         total++; if (out_valid_c !== 1'b1) begin bad++; $display("FAIL comb_valid[%0d] got=%b exp=1", k, out_valid_c); end
         total++; if (out_ctrl_c !== ectl[k]) begin bad++; $display("FAIL comb_ctrl[%0d] got=%h exp=%h", k, out_ctrl_c, ectl[k]); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      total++; if (out_valid_c !== 1'b0) begin bad++; $display("FAIL comb_drain got=%b exp=0", out_valid_c); end
   endtask

   task automatic test_saturate();
      logic [1:0] ecnt [6];
      ecnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'h61; in_data = 128'h600;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         total++; if (stall_cnt_d !== ecnt[k]) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, stall_cnt_d, ecnt[k]); end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'h71; in_data = 128'h700;
      tick();
      in_ctrl = 8'h72; in_data = 128'h701;
      tick();
      total++; if (stall_cnt_a !== 16'd1) begin bad++; $display("FAIL mr_stall_before got=%0d exp=1", stall_cnt_a); end
      rst = 1'b1; in_ctrl = 8'h73; in_data = 128'h702;
      #1;
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL mr_ready_in_rst got=%b exp=0", in_ready_a); end
      tick();
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", out_valid_a); end
      total++; if (out_ctrl_a !== 8'h00) begin bad++; $display("FAIL mr_ctrl got=%h exp=00", out_ctrl_a); end
      total++; if (out_data_a !== 128'h0) begin bad++; $display("FAIL mr_data got=%h exp=0", out_data_a); end
      total++; if (stall_cnt_a !== 16'd0) begin bad++; $display("FAIL mr_stall got=%0d exp=0", stall_cnt_a); end
      rst = 1'b0; out_ready = 1'b1; in_ctrl = 8'h74; in_data = 128'h703;
      #1;
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL mr_ready_after got=%b exp=1", in_ready_a); end
      tick();
      in_valid = 1'b0;
      total++; if (out_ctrl_a !== 8'h74) begin bad++; $display("FAIL mr_next_ctrl got=%h exp=74", out_ctrl_a); end
      tick();
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL mr_no_stale got=%b exp=0", out_valid_a); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      in_ctrl = '0; in_data = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_clear();
      test_flush_hold();
      test_comb_ready();
      test_saturate();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timed out");
   end

endmodule
